// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the LSU cache requester.
//   - RV32I funct3 width codes for loads and stores
//   - FSM state encoding
//   - helpers: request legality, alignment, load lane select, store merge
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StRmwRd,
    StRmwWr,
    StDone
  } lsu_state_e;

  function automatic logic f3_illegal(logic we, logic [2:0] f3);
    if (we) return f3 > F3_SW;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Offending low address bits are dropped so a misaligned access hits its natural lane.
  function automatic logic [1:0] align_off(logic [2:0] f3, logic [1:0] off);
    case (f3[1:0])
      2'b01:   return {off[1], 1'b0};
      2'b10:   return 2'b00;
      default: return off;
    endcase
  endfunction

  function automatic logic [31:0] lane_select(logic [31:0] word, logic [1:0] off, logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'h0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(logic [31:0] word, logic [31:0] wdata,
                                             logic [1:0] off, logic [2:0] f3);
    logic [31:0] w;
    w = word;
    case (f3)
      F3_SB:   w[{off, 3'b000} +: 8] = wdata[7:0];
      F3_SH:   w[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: w = wdata;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_formatter.sv
// lsu_load_formatter: combinational lane logic shared by loads and sub-word stores.
//   rd_i      cache read word
//   off_i     byte offset within the word (already aligned for the access size)
//   funct3_i  RV32I width/sign code
//   wdata_i   store data (low bits used for SB/SH)
//   rdata_o   formatted load result
//   merged_o  rd_i with the store lane(s) replaced by wdata_i
module lsu_load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] rd_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [31:0] merged_o
);

  assign rdata_o  = lane_select(rd_i, off_i, funct3_i);
  assign merged_o = merge_word(rd_i, wdata_i, off_i, funct3_i);

endmodule

// File: rtl/lsu_cache_requester.sv
// lsu_cache_requester: MEM-stage initiator for the word-only cache request/stall port.
// Holds one load/store at a time; sub-word stores run as read-modify-write.
//   clk, rst (sync, active-high)
//   lsu_req/we/funct3/addr/wdata  request from MEM stage, accepted when lsu_req & lsu_ready
//   lsu_ready/stall/done/rdata/err  handshake and result back to MEM stage
//   Addr/WD/RE/WE/RD/Mem_Stall     cache port; access completes on an edge with ~Mem_Stall
// STALL_TIMEOUT: stall cycles per access before abort with lsu_err (0 disables the watchdog).
// Define LSU_MISALIGN_TRAP_EN to flag misaligned LH/LHU/SH/LW/SW as errors instead of
// forcing alignment.
module lsu_cache_requester
  import lsu_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ready,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] Addr,
  output logic [31:0] WD,
  output logic        WE,
  output logic        RE,
  input  logic [31:0] RD,
  input  logic        Mem_Stall
);

  lsu_state_e  state_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] addr_q, wd_q, rdata_q, timer_q;
  logic        re_q, we_q, done_q, err_q;

  logic [1:0]  req_off;
  logic        req_bad;
  logic        timeout;
  logic [31:0] fmt_rdata, merged;

  always_comb begin
    req_off = align_off(lsu_funct3, lsu_addr[1:0]);
    req_bad = f3_illegal(lsu_we, lsu_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
    req_bad = req_bad | f3_misaligned(lsu_funct3, lsu_addr[1:0]);
`endif
  end

  // The current stall cycle is the STALL_TIMEOUT-th one when the counter already shows N-1.
  assign timeout = (STALL_TIMEOUT != 0) && (timer_q >= STALL_TIMEOUT - 32'd1);

  lsu_load_formatter u_fmt (
    .rd_i     (RD),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .wdata_i  (wdata_q),
    .rdata_o  (fmt_rdata),
    .merged_o (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      wdata_q <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      timer_q <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          if (lsu_req) begin
            off_q   <= req_off;
            f3_q    <= lsu_funct3;
            wdata_q <= lsu_wdata;
            if (req_bad) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              addr_q <= {lsu_addr[31:2], 2'b00};
              if (!lsu_we) begin
                re_q    <= 1'b1;
                state_q <= StRead;
              end else if (lsu_funct3 == F3_SW) begin
                we_q    <= 1'b1;
                wd_q    <= lsu_wdata;
                state_q <= StWrite;
              end else begin
                re_q    <= 1'b1;
                state_q <= StRmwRd;
              end
            end
          end
        end
        StRead, StWrite, StRmwRd, StRmwWr: begin
          if (Mem_Stall) begin
            if (timeout) begin
              re_q    <= 1'b0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= StDone;
            end else if (timer_q != '1) begin
              timer_q <= timer_q + 32'd1;
            end
          end else begin
            timer_q <= '0;
            if (state_q == StRmwRd) begin
              re_q    <= 1'b0;
              we_q    <= 1'b1;
              wd_q    <= merged;
              state_q <= StRmwWr;
            end else begin
              re_q    <= 1'b0;
              we_q    <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
              if (state_q == StRead) rdata_q <= fmt_rdata;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lsu_ready = (state_q == StIdle);
  assign lsu_stall = (lsu_req & lsu_ready) |
                     (state_q inside {StRead, StWrite, StRmwRd, StRmwWr});
  assign lsu_done  = done_q;
  assign lsu_err   = err_q;
  assign lsu_rdata = rdata_q;
  assign Addr      = addr_q;
  assign WD        = wd_q;
  assign RE        = re_q;
  assign WE        = we_q;

endmodule

// File: tb/tb_lsu_cache_requester.sv
module tb_lsu_cache_requester;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_ready, lsu_stall, lsu_done, lsu_err;
  logic [31:0] lsu_rdata, Addr, WD, RD;
  logic        WE, RE, Mem_Stall;

  int n_checks = 0;
  int n_errors = 0;

  lsu_cache_requester #(.STALL_TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .lsu_req    (lsu_req),
    .lsu_we     (lsu_we),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_ready  (lsu_ready),
    .lsu_stall  (lsu_stall),
    .lsu_done   (lsu_done),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .Addr       (Addr),
    .WD         (WD),
    .WE         (WE),
    .RE         (RE),
    .RD         (RD),
    .Mem_Stall  (Mem_Stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cache model: 64-word memory window, programmable stall length per access.
  logic [31:0] mem      [64];
  logic [31:0] init_val [64];
  logic [31:0] ref_mem  [64];
  logic        mem_load, force_stall, idle_noise;
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          re_total = 0;
  int          we_total = 0;

  assign RD = mem[Addr[7:2]];
  assign Mem_Stall = force_stall | ((RE | WE) ? (stall_cnt < stall_len) : idle_noise);

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val[i];
    end else if (WE && !Mem_Stall) begin
      mem[Addr[7:2]] <= WD;
    end
    stall_cnt <= ((RE || WE) && Mem_Stall) ? stall_cnt + 1 : 0;
    if (RE) re_total <= re_total + 1;
    if (WE) we_total <= we_total + 1;
  end

  always @(negedge clk) begin
    if (!rst && (RE || WE)) begin
      check("re_we_excl", 32'(RE & WE), 32'd0);
      check("addr_align", 32'(Addr[1:0]), 32'd0);
    end
  end

  // Reference model: request semantics from access size and byte offset.
  logic [31:0] last_rdata = '0;

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic illegal(input logic we, input logic [2:0] f3);
    return we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
  endfunction

  function automatic logic misal(input logic [2:0] f3, input logic [31:0] a);
    return (a % size_of(f3)) != 0;
  endfunction

  function automatic logic [1:0] eff_off(input logic [2:0] f3, input logic [31:0] a);
    return 2'((a % 4) - (a % size_of(f3)));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
    logic [31:0] sh;
    sh = w >> (8 * off);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd4:    return 32'(sh[7:0]);
      3'd5:    return 32'(sh[15:0]);
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    mask = (size_of(f3) == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size_of(f3))) - 32'h1;
    mask = mask << (8 * off);
    return (old & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // One request from an idle negedge to the negedge after its done pulse.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int slen, input logic fst);
    logic       bad, abort;
    logic [1:0] off;
    logic [5:0] idx;
    int         lat, re0, we0, exp_lat, exp_re, exp_we;
    bad = illegal(we, f3);
`ifdef LSU_MISALIGN_TRAP_EN
    if (!bad && misal(f3, a)) bad = 1'b1;
`endif
    abort = fst && !bad;
    off = eff_off(f3, a);
    idx = a[7:2];
    stall_len = slen;
    force_stall = fst;
    check("ready_idle", 32'(lsu_ready), 32'd1);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
    #1;
    check("stall_on_req", 32'(lsu_stall), 32'd1);
    re0 = re_total; we0 = we_total;
    @(posedge clk);
    @(negedge clk);
    lsu_req = 1'b0;
    lsu_addr = $urandom;
    lat = 0;
    if (!bad) check("busy_stall", 32'({lsu_stall, lsu_ready}), 32'b10);
    while (!lsu_done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("done_seen", 32'(lsu_done), 32'd1);
    if (bad) exp_lat = 0;
    else if (abort) exp_lat = int'(TO);
    else if (we && size_of(f3) < 4) exp_lat = 2 + 2 * slen;
    else exp_lat = 1 + slen;
    check("latency", 32'(lat), 32'(exp_lat));
    check("err", 32'(lsu_err), 32'(bad || abort));
    check("stall_in_done", 32'(lsu_stall), 32'd0);
    if (!bad) check("cache_addr", Addr, {a[31:2], 2'b00});
    if (!bad && !abort) begin
      if (!we) last_rdata = model_load(ref_mem[idx], f3, off);
      else ref_mem[idx] = model_store(ref_mem[idx], wd, f3, off);
    end
    if (!we || bad || abort) check("rdata", lsu_rdata, last_rdata);
    @(negedge clk);
    check("done_pulse", 32'({lsu_done, lsu_err}), 32'd0);
    check("ready_after", 32'(lsu_ready), 32'd1);
    check("mem_word", mem[idx], ref_mem[idx]);
    exp_re = 0; exp_we = 0;
    if (abort) begin
      if (we && size_of(f3) == 4) exp_we = int'(TO);
      else exp_re = int'(TO);
    end else if (!bad) begin
      if (!we || size_of(f3) < 4) exp_re = 1 + slen;
      if (we) exp_we = 1 + slen;
    end
    check("re_cycles", 32'(re_total - re0), 32'(exp_re));
    check("we_cycles", 32'(we_total - we0), 32'(exp_we));
    force_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_load = 1'b1; force_stall = 1'b0; idle_noise = 1'b0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = '0; lsu_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      init_val[i] = $urandom;
      ref_mem[i]  = init_val[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; mem_load = 1'b0;
    check("rst_ready", 32'(lsu_ready), 32'd1);
    check("rst_en", 32'({RE, WE, lsu_done, lsu_err, lsu_stall}), 32'd0);
    check("rst_addr", Addr, 32'd0);
    check("rst_wd", WD, 32'd0);
    check("rst_rdata", lsu_rdata, 32'd0);

    // Directed cases.
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b0);          // LW, no stall
    check("lw_rdata", lsu_rdata, ref_mem[0]);
    do_op(1'b1, 3'd2, 32'h100, 32'h80FF_1234, 0, 1'b0);
    do_op(1'b0, 3'd0, 32'h103, 32'h0, 5, 1'b0);          // LB with 5 stalls
    check("lb_sext", lsu_rdata, 32'hFFFF_FF80);
    do_op(1'b1, 3'd2, 32'h100, 32'h1122_3344, 0, 1'b0);
    do_op(1'b1, 3'd0, 32'h102, 32'h0000_00AB, 0, 1'b0);  // SB via RMW
    check("sb_wd", WD, 32'h11AB_3344);
    do_op(1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b0);
    check("sb_result", lsu_rdata, 32'h11AB_3344);
    do_op(1'b0, 3'd2, 32'h104, 32'h0, 0, 1'b1);          // LW watchdog
    do_op(1'b1, 3'd0, 32'h108, 32'h5A, 0, 1'b1);         // SB watchdog in RMW read
    do_op(1'b1, 3'd2, 32'h10C, 32'h5A5A, 0, 1'b1);       // SW watchdog
    do_op(1'b0, 3'd2, 32'h102, 32'h0, 1, 1'b0);          // misaligned LW
`ifndef LSU_MISALIGN_TRAP_EN
    check("lw_forced_align", lsu_rdata, 32'h11AB_3344);
`endif
    do_op(1'b0, 3'd3, 32'h100, 32'h0, 0, 1'b0);          // illegal load
    do_op(1'b1, 3'd5, 32'h100, 32'h0, 0, 1'b0);          // illegal store

    // Reset in the middle of an SH read-modify-write.
    force_stall = 1'b1;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'd1; lsu_addr = 32'h112; lsu_wdata = 32'hBEEF;
    @(posedge clk);
    @(negedge clk);
    lsu_req = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_re", 32'(RE), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_en", 32'({RE, WE, lsu_done, lsu_err}), 32'd0);
    check("rstmid_ready", 32'(lsu_ready), 32'd1);
    rst = 1'b0; force_stall = 1'b0;
    @(negedge clk);
    check("rstmid_mem", mem[4], ref_mem[4]);
    last_rdata = '0;

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      logic [2:0] f3;
      logic       w;
      w = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) :
           (w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
      idle_noise = 1'($urandom);
      do_op(w, f3, $urandom, $urandom, $urandom_range(0, 4), $urandom_range(0, 24) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
